// File: rtl/audio_pkg.sv
// Shared types, default sample-ROM regions and PCM conversion for the sound-effect sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY_START,
    PLAY_CHOMP,
    PLAY_EATGHOST,
    PLAY_DEATH
  } state_t;

  localparam int DEF_ADDR_W     = 16;

  // Default layout of the shared sample ROM, one contiguous region per effect.
  localparam int DEF_START_BASE = 0;
  localparam int DEF_START_LEN  = 50000;
  localparam int DEF_CHOMP_BASE = 50000;
  localparam int DEF_CHOMP_LEN  = 4000;
  localparam int DEF_EATG_BASE  = 54000;
  localparam int DEF_EATG_LEN   = 4000;
  localparam int DEF_DEATH_BASE = 58000;
  localparam int DEF_DEATH_LEN  = 7536;

  // Unsigned 8-bit sample -> signed, left-justified 24-bit PCM.
  // Flipping the MSB turns offset-binary into two's complement.
  function automatic logic [23:0] pcm_from_u8(input logic [7:0] s);
    return {s ^ 8'h80, 16'h0000};
  endfunction

endpackage

// File: rtl/play_audio_if.sv
// Request, sample-ROM and codec DAC write bundle for the sound-effect sequencer.
// Latency: n/a (signal bundle).
// Backpressure: write_ready from the codec gates write; the master side never writes without it.
// master: the sequencer (drives rom_addr, write, writedata_*, busy).
// slave:  the surrounding game/ROM/codec logic (drives requests, rom_q, write_ready).
interface play_audio_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              chomp;
  logic              eatghost;
  logic              death;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic              write_ready;
  logic              write;
  logic [23:0]       writedata_left;
  logic [23:0]       writedata_right;
  logic              busy;

  modport master (
    input  start, chomp, eatghost, death, rom_q, write_ready,
    output rom_addr, write, writedata_left, writedata_right, busy
  );

  modport slave (
    output start, chomp, eatghost, death, rom_q, write_ready,
    input  rom_addr, write, writedata_left, writedata_right, busy
  );
endinterface

// File: rtl/sample_addr_counter.sv
// Loadable sample ROM address / offset counter with a terminal flag at offset LEN-1.
// Latency: load and increment take effect at the next CLOCK_50 edge; terminal is combinational.
// Backpressure: holds its value whenever neither load nor inc is asserted.
// Ports: CLOCK_50/reset, load+base (start of region), inc (step), len (region length),
//        addr (ROM address), offset (position within region), terminal (offset == len-1).
module sample_addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              inc,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] offset,
  output logic              terminal
);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      addr   <= '0;
      offset <= '0;
    end else if (load) begin
      addr   <= base;
      offset <= '0;
    end else if (inc) begin
      addr   <= addr + 1'b1;
      offset <= offset + 1'b1;
    end
  end

  assign terminal = (offset == (len - 1'b1));

endmodule

// File: rtl/play_audio.sv
// Sound-effect sequencer: on a one-cycle request, streams that effect's ROM samples to the codec as 24-bit PCM.
// Latency: request at edge N -> ROM address at N+1 -> first write possible at N+2; two cycles minimum per sample.
// Backpressure: write_ready low freezes address/offset; requests while playing are dropped, not queued.
// Ports: CLOCK_50, reset (async, active low), aif (requests, ROM address/data, codec write, busy).
module play_audio
  import audio_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int START_BASE = DEF_START_BASE,
  parameter int START_LEN  = DEF_START_LEN,
  parameter int CHOMP_BASE = DEF_CHOMP_BASE,
  parameter int CHOMP_LEN  = DEF_CHOMP_LEN,
  parameter int EATG_BASE  = DEF_EATG_BASE,
  parameter int EATG_LEN   = DEF_EATG_LEN,
  parameter int DEATH_BASE = DEF_DEATH_BASE,
  parameter int DEATH_LEN  = DEF_DEATH_LEN
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  play_audio_if.master  aif
);

  localparam logic [ADDR_W-1:0] START_B = ADDR_W'(START_BASE);
  localparam logic [ADDR_W-1:0] START_L = ADDR_W'(START_LEN);
  localparam logic [ADDR_W-1:0] CHOMP_B = ADDR_W'(CHOMP_BASE);
  localparam logic [ADDR_W-1:0] CHOMP_L = ADDR_W'(CHOMP_LEN);
  localparam logic [ADDR_W-1:0] EATG_B  = ADDR_W'(EATG_BASE);
  localparam logic [ADDR_W-1:0] EATG_L  = ADDR_W'(EATG_LEN);
  localparam logic [ADDR_W-1:0] DEATH_B = ADDR_W'(DEATH_BASE);
  localparam logic [ADDR_W-1:0] DEATH_L = ADDR_W'(DEATH_LEN);

  state_t            state;
  state_t            req_state;
  logic              rom_wait;
  logic              any_req;
  logic              playing;
  logic              accept;
  logic              load;
  logic              inc;
  logic              terminal;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] cur_len;
  logic [ADDR_W-1:0] offset;

  // Fixed priority: start > chomp > eatghost > death.
  always_comb begin
    req_state = IDLE;
    req_base  = START_B;
    if (aif.start) begin
      req_state = PLAY_START;
      req_base  = START_B;
    end else if (aif.chomp) begin
      req_state = PLAY_CHOMP;
      req_base  = CHOMP_B;
    end else if (aif.eatghost) begin
      req_state = PLAY_EATGHOST;
      req_base  = EATG_B;
    end else if (aif.death) begin
      req_state = PLAY_DEATH;
      req_base  = DEATH_B;
    end
  end

  always_comb begin
    cur_len = START_L;
    case (state)
      PLAY_CHOMP:    cur_len = CHOMP_L;
      PLAY_EATGHOST: cur_len = EATG_L;
      PLAY_DEATH:    cur_len = DEATH_L;
      default:       cur_len = START_L;
    endcase
  end

  assign any_req = aif.start | aif.chomp | aif.eatghost | aif.death;
  assign playing = (state != IDLE);
  // rom_wait covers the ROM's one-cycle read latency after every address change.
  assign accept  = aif.write_ready & ~rom_wait;
  assign load    = ~playing & any_req;
  assign inc     = playing & accept & ~terminal;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rom_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rom_wait <= any_req;
          if (any_req) state <= req_state;
        end
        default: begin
          // Accept is impossible while waiting, so this also clears a pending wait.
          rom_wait <= accept & ~terminal;
          if (accept && terminal) state <= IDLE;
        end
      endcase
    end
  end

  sample_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (load),
    .base     (req_base),
    .inc      (inc),
    .len      (cur_len),
    .addr     (aif.rom_addr),
    .offset   (offset),
    .terminal (terminal)
  );

  // The codec is fed continuously; in IDLE it receives silence.
  assign aif.write           = accept;
  assign aif.writedata_left  = playing ? pcm_from_u8(aif.rom_q) : 24'h000000;
  assign aif.writedata_right = aif.writedata_left;
  assign aif.busy            = playing;

endmodule

// File: tb/tb_play_audio.sv
module tb_play_audio;
  import audio_pkg::*;

  localparam int AW          = 16;
  localparam int T_START_LEN = 2000;  // shortened start jingle keeps the run short

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  play_audio_if #(.ADDR_W(AW)) aif ();

  play_audio #(
    .ADDR_W    (AW),
    .START_LEN (T_START_LEN)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .aif      (aif)
  );

  // Sample ROM model: registered read, data = addr[7:0] ^ addr[15:8].
  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  initial aif.rom_q = 8'h00;
  always @(posedge CLOCK_50) aif.rom_q <= rom_fn(aif.rom_addr);

  // Reference model: effect id (0 = idle), position, address, and "sample not yet readable".
  int base_of [5] = '{0, 0, 50000, 54000, 58000};
  int len_of  [5] = '{1, T_START_LEN, 4000, 4000, 7536};
  int m_eff, m_idx, m_addr;
  bit m_pend;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_eff = 0; m_idx = 0; m_addr = 0; m_pend = 0;
  endtask

  task automatic check_outputs(input bit wr);
    bit     exp_w;
    longint exp_d;
    exp_w = wr && !m_pend;
    chk("busy", aif.busy, (m_eff != 0));
    chk("write", aif.write, exp_w);
    chk("rom_addr", aif.rom_addr, m_addr);
    if (m_eff == 0) begin
      chk("wdata_l_idle", aif.writedata_left, 0);
      chk("wdata_r_idle", aif.writedata_right, 0);
    end else if (exp_w) begin
      exp_d = longint'((int'(rom_fn(16'(m_addr))) ^ 128) * 65536);
      chk("wdata_l_sample", aif.writedata_left, exp_d);
      chk("wdata_r_sample", aif.writedata_right, exp_d);
    end
    if (aif.write && wr && aif.busy) acc_cnt++;
  endtask

  task automatic model_step(input bit s, c, e, d, wr);
    int eff;
    if (m_eff == 0) begin
      eff = s ? 1 : c ? 2 : e ? 3 : d ? 4 : 0;
      if (eff != 0) begin
        m_eff = eff; m_idx = 0; m_addr = base_of[eff]; m_pend = 1;
      end
    end else if (m_pend) begin
      m_pend = 0;
    end else if (wr) begin
      if (m_idx == len_of[m_eff] - 1) m_eff = 0;
      else begin
        m_idx++; m_addr++; m_pend = 1;
      end
    end
  endtask

  task automatic cycle(input bit s, c, e, d, wr);
    aif.start = s; aif.chomp = c; aif.eatghost = e; aif.death = d; aif.write_ready = wr;
    @(negedge CLOCK_50);
    check_outputs(wr);
    @(posedge CLOCK_50);
    model_step(s, c, e, d, wr);
    #1;
  endtask

  task automatic do_reset();
    aif.start = 0; aif.chomp = 0; aif.eatghost = 0; aif.death = 0; aif.write_ready = 1;
    reset = 1'b0;
    m_reset();
    @(negedge CLOCK_50);
    check_outputs(1'b1);
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
  endtask

  // True in the cycle that carries the final accepted sample when write_ready is high.
  function automatic bit final_cycle();
    return (m_eff != 0) && !m_pend && (m_idx == len_of[m_eff] - 1);
  endfunction

  // Plays the current effect out; mode 0 = write_ready always 1, mode 1 = random write_ready
  // and random (ignored) requests. A death request is raised on the final write.
  task automatic run_to_idle(input string nm, input int mode, input int limit);
    int n;
    bit wr;
    n = 0;
    while (aif.busy && n < limit) begin
      wr = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (mode == 1 && !final_cycle())
        cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, wr);
      else
        cycle(1'b0, 1'b0, 1'b0, wr && final_cycle(), wr);
      n++;
    end
    chk({nm, "_timeout"}, (n < limit), 1);
    cycle(0, 0, 0, 0, 1);  // a request on the final write must not have started anything
  endtask

  typedef struct {
    bit     s, c, e, d;
    int     exp_addr;
    state_t exp_state;
  } vec_t;

  initial begin
    vec_t vt [6];
    int   saved_addr, saved_off, n;

    vt[0] = '{1, 1, 1, 1, 0,     PLAY_START};
    vt[1] = '{0, 1, 0, 1, 50000, PLAY_CHOMP};
    vt[2] = '{0, 0, 1, 1, 54000, PLAY_EATGHOST};
    vt[3] = '{0, 0, 0, 1, 58000, PLAY_DEATH};
    vt[4] = '{0, 1, 1, 0, 50000, PLAY_CHOMP};
    vt[5] = '{1, 0, 0, 1, 0,     PLAY_START};

    // Reset and idle
    aif.start = 0; aif.chomp = 0; aif.eatghost = 0; aif.death = 0; aif.write_ready = 1;
    m_reset();
    repeat (2) begin
      @(negedge CLOCK_50);
      check_outputs(1'b1);
    end
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
    repeat (5) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Request priority from IDLE
    for (int i = 0; i < 6; i++) begin
      cycle(vt[i].s, vt[i].c, vt[i].e, vt[i].d, 1);
      chk("tbl_addr", aif.rom_addr, vt[i].exp_addr);
      chk("tbl_state", int'(dut.state), int'(vt[i].exp_state));
      chk("tbl_busy", aif.busy, 1);
      chk("tbl_write", aif.write, 0);
      do_reset();
    end

    // Start jingle at full rate
    acc_cnt = 0;
    cycle(1, 0, 0, 0, 1);
    run_to_idle("start", 0, 2 * T_START_LEN + 20);
    chk("start_writes", acc_cnt, T_START_LEN);
    chk("start_end_addr", aif.rom_addr, T_START_LEN - 1);

    // Chomp with a simultaneous death, an ignored death pulse, and a 100-cycle stall
    acc_cnt = 0;
    cycle(0, 1, 0, 1, 1);
    chk("chomp_state", int'(dut.state), int'(PLAY_CHOMP));
    chk("chomp_first_addr", aif.rom_addr, 50000);
    repeat (301) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    chk("chomp_after_death_state", int'(dut.state), int'(PLAY_CHOMP));
    repeat (40) cycle(0, 0, 0, 0, 1);
    saved_addr = m_addr;
    saved_off  = m_idx;
    repeat (100) cycle(0, 0, 0, 0, 0);
    chk("bp_addr_frozen", aif.rom_addr, saved_addr);
    chk("bp_offset_frozen", dut.u_cnt.offset, saved_off);
    run_to_idle("chomp", 0, 8100);
    chk("chomp_writes", acc_cnt, 4000);
    chk("chomp_end_addr", aif.rom_addr, 53999);
    chk("chomp_end_busy", aif.busy, 0);

    // Eat-ghost under random backpressure and random ignored requests
    acc_cnt = 0;
    cycle(0, 0, 1, 0, 1);
    run_to_idle("eatg", 1, 20000);
    chk("eatg_writes", acc_cnt, 4000);
    chk("eatg_end_addr", aif.rom_addr, 57999);

    // Free-running random traffic in and out of IDLE
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0);

    // Reset in the middle of the death effect
    do_reset();
    acc_cnt = 0;
    cycle(0, 0, 0, 1, 1);
    n = 0;
    while (acc_cnt < 10 && n < 100) begin
      cycle(0, 0, 0, 0, 1);
      n++;
    end
    chk("death_reach_timeout", (n < 100), 1);
    chk("death_offset", dut.u_cnt.offset, 10);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", aif.busy, 0);
    chk("rst_mid_wdata", aif.writedata_left, 0);
    chk("rst_mid_addr", aif.rom_addr, 0);
    chk("rst_mid_write", aif.write, 1);
    m_reset();
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
    repeat (4) cycle(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
